// File: rtl/johnson_phase_decoder.sv
// rtl/johnson_phase_decoder.sv - Johnson code phase decoder, integrity checker and CEO divider
// Optional feature: define JPD_SEQ_CHECK_EN to enable the step-to-step sequence check.
module johnson_phase_decoder #(
  parameter int DIV   = 4,
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ce,
  input  logic             clr,
  input  logic [3:0]       q,
  input  logic             ceo,
  input  logic             err_clr,
  output logic [7:0]       phase,
  output logic [2:0]       idx,
  output logic             legal,
  output logic             code_err,
  output logic             seq_err,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             tick
);

  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [CNT_W-1:0] WRAP_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] WRAP_ONE  = CNT_W'(1);

  logic [2:0] dec_idx;
  logic       dec_legal;
  logic       seq_mis;
  logic       new_err;

  // Map the current Johnson code to its phase index; anything else is illegal
  always_comb begin
    dec_idx   = 3'd0;
    dec_legal = 1'b1;
    case (q)
      4'b0000: dec_idx = 3'd0;
      4'b0001: dec_idx = 3'd1;
      4'b0011: dec_idx = 3'd2;
      4'b0111: dec_idx = 3'd3;
      4'b1111: dec_idx = 3'd4;
      4'b1110: dec_idx = 3'd5;
      4'b1100: dec_idx = 3'd6;
      4'b1000: dec_idx = 3'd7;
      default: dec_legal = 1'b0;
    endcase
  end

`ifdef JPD_SEQ_CHECK_EN
  logic       prev_vld;
  logic       prev_legal;
  logic       prev_ce;
  logic       prev_clr;
  logic [2:0] prev_idx;
  logic [2:0] exp_idx;

  // Predict the index this sample must carry, given what the counter was told last cycle.
  // Legal codes map one-to-one onto indices, so comparing indices equals comparing codes.
  always_comb begin
    exp_idx = prev_idx;
    if (prev_clr) begin
      exp_idx = 3'd0;
    end else if (prev_ce) begin
      exp_idx = prev_idx + 3'd1;
    end
    seq_mis = prev_vld & prev_legal & dec_legal & (dec_idx != exp_idx);
  end

  // Remember the previous sample for the successor check
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_vld   <= 1'b0;
      prev_legal <= 1'b0;
      prev_ce    <= 1'b0;
      prev_clr   <= 1'b0;
      prev_idx   <= 3'd0;
    end else begin
      prev_vld   <= 1'b1;
      prev_legal <= dec_legal;
      prev_ce    <= ce;
      prev_clr   <= clr;
      prev_idx   <= dec_idx;
    end
  end
`else
  // Without the successor check the counter's enable has no consumer here
  logic unused_ce;
  assign unused_ce = ce;
  assign seq_mis   = 1'b0;
`endif

  assign new_err = ~dec_legal | seq_mis;

  // Register decode results and single-cycle error pulses
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      phase    <= 8'd0;
      idx      <= 3'd0;
      legal    <= 1'b0;
      code_err <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      phase    <= dec_legal ? (8'd1 << dec_idx) : 8'd0;
      idx      <= dec_idx;
      legal    <= dec_legal;
      code_err <= ~dec_legal;
      seq_err  <= seq_mis;
    end
  end

  // Sticky flag and saturating counter; a fresh error outranks err_clr
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (new_err) begin
      err_sticky <= 1'b1;
      if (err_clr) begin
        err_cnt <= ERR_ONE;
      end else if (err_cnt != ERR_MAX) begin
        err_cnt <= err_cnt + ERR_ONE;
      end
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end
  end

  // Divide CEO pulses by DIV; the counter's clear restarts the division and suppresses the tick
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wrap_cnt <= '0;
      tick     <= 1'b0;
    end else if (clr) begin
      wrap_cnt <= '0;
      tick     <= 1'b0;
    end else if (ceo) begin
      if (wrap_cnt == WRAP_LAST) begin
        wrap_cnt <= '0;
        tick     <= 1'b1;
      end else begin
        wrap_cnt <= wrap_cnt + WRAP_ONE;
        tick     <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb/tb_johnson_phase_decoder.sv - self-checking bench for johnson_phase_decoder
module tb_johnson_phase_decoder;

  localparam int DIV     = 4;
  localparam int CNT_W   = 8;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
`ifdef JPD_SEQ_CHECK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             ce = 1'b0;
  logic             clr = 1'b0;
  logic [3:0]       q = 4'd0;
  logic             ceo = 1'b0;
  logic             err_clr = 1'b0;
  logic [7:0]       phase;
  logic [2:0]       idx;
  logic             legal;
  logic             code_err;
  logic             seq_err;
  logic             err_sticky;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] wrap_cnt;
  logic             tick;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_on   = 1'b0;

  logic [3:0] codes   [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hf, 4'he, 4'hc, 4'h8};
  logic [3:0] illegal [8] = '{4'h2, 4'h4, 4'h5, 4'h6, 4'h9, 4'ha, 4'hb, 4'hd};

  always #5 clk = ~clk;

  johnson_phase_decoder #(.DIV(DIV), .CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .clr_n(clr_n), .ce(ce), .clr(clr), .q(q), .ceo(ceo), .err_clr(err_clr),
    .phase(phase), .idx(idx), .legal(legal), .code_err(code_err), .seq_err(seq_err),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt), .tick(tick)
  );

  // Reference model state
  logic [7:0] m_phase;
  int         m_idx, m_cnt, m_wrap, p_idx;
  bit         m_legal, m_code_err, m_seq_err, m_sticky, m_tick;
  bit         p_vld, p_ce, p_clr;

  function automatic int code_index(input logic [3:0] c);
    for (int k = 0; k < 8; k++) if (codes[k] == c) return k;
    return -1;
  endfunction

  function automatic bit seq_bad();
    int ci, ex;
    ci = code_index(q);
    if (!SEQ_EN || !p_vld || p_idx < 0 || ci < 0) return 1'b0;
    ex = p_clr ? 0 : (p_ce ? (p_idx + 1) % 8 : p_idx);
    return ci != ex;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_phase <= 8'd0; m_idx <= 0; m_legal <= 0; m_code_err <= 0; m_seq_err <= 0;
      m_sticky <= 0; m_cnt <= 0; m_wrap <= 0; m_tick <= 0;
      p_vld <= 0; p_ce <= 0; p_clr <= 0; p_idx <= -1;
    end else begin
      m_legal    <= code_index(q) >= 0;
      m_idx      <= (code_index(q) >= 0) ? code_index(q) : 0;
      m_phase    <= (code_index(q) >= 0) ? 8'(1 << code_index(q)) : 8'd0;
      m_code_err <= code_index(q) < 0;
      m_seq_err  <= seq_bad();
      if (code_index(q) < 0 || seq_bad()) begin
        m_sticky <= 1'b1;
        m_cnt    <= err_clr ? 1 : ((m_cnt < ERR_MAX) ? m_cnt + 1 : ERR_MAX);
      end else if (err_clr) begin
        m_sticky <= 1'b0;
        m_cnt    <= 0;
      end
      if (clr) begin
        m_wrap <= 0; m_tick <= 1'b0;
      end else if (ceo) begin
        m_wrap <= (m_wrap + 1) % DIV;
        m_tick <= (m_wrap + 1) == DIV;
      end else begin
        m_tick <= 1'b0;
      end
      p_vld <= 1'b1; p_idx <= code_index(q); p_ce <= ce; p_clr <= clr;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_on) begin
      check("phase", phase, m_phase);
      check("idx", idx, m_idx);
      check("legal", legal, m_legal);
      check("code_err", code_err, m_code_err);
      check("seq_err", seq_err, m_seq_err);
      check("err_sticky", err_sticky, m_sticky);
      check("err_cnt", err_cnt, m_cnt);
      check("wrap_cnt", wrap_cnt, m_wrap);
      check("tick", tick, m_tick);
    end
  end

  task automatic step(input logic [3:0] qv, input bit cev, input bit clrv, input bit ceov, input bit ecv);
    @(negedge clk);
    q = qv; ce = cev; clr = clrv; ceo = ceov; err_clr = ecv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ticks;
    int rc;
    logic [3:0] qv;
    bit cev, clrv, ceov, ecv;

    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_legal", legal, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_wrap", wrap_cnt, 0);
    check("rst_tick", tick, 0);
    chk_on = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;

    // Free-running counter from 0000
    for (int i = 0; i < 16; i++) begin
      step(codes[i % 8], 1'b1, 1'b0, codes[i % 8] == 4'hf, 1'b0);
      if (i == 0) check("t1_phase_first", phase, 8'h01);
    end
    check("t1_phase_last", phase, 8'h80);
    check("t1_wrap", wrap_cnt, 2);
    check("t1_tick", tick, 0);
    check("t1_err_cnt", err_cnt, 0);
    step(4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_phase_wrap", phase, 8'h01);

    // Illegal codes
    step(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_code_err_a", code_err, 1);
    check("t2_legal", legal, 0);
    check("t2_phase", phase, 0);
    step(4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_code_err_b", code_err, 1);
    check("t2_seq_err", seq_err, 0);
    check("t2_err_cnt", err_cnt, 2);
    check("t2_sticky", err_sticky, 1);

    // Skipped step
    step(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_seq_err", seq_err, SEQ_EN ? 1 : 0);
    check("t3_code_err", code_err, 0);
    check("t3_err_cnt", err_cnt, SEQ_EN ? 3 : 2);

    // Hold with ce=0, then a change while still disabled
    step(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b1100, 1'b1, 1'b1, 1'b0, 1'b0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);
      check("t4_hold_seq", seq_err, 0);
    end
    check("t4_hold_cnt", err_cnt, SEQ_EN ? 3 : 2);
    step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_change_seq", seq_err, SEQ_EN ? 1 : 0);
    check("t4_change_cnt", err_cnt, SEQ_EN ? 4 : 2);

    // Saturation and err_clr racing an error
    for (int i = 0; i < 20; i++) step(illegal[i % 8], 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_sat", err_cnt, 15);
    check("t5_sticky", err_sticky, 1);
    step(4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_clr_race_cnt", err_cnt, 1);
    check("t5_clr_race_sticky", err_sticky, 1);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_clr_cnt", err_cnt, 0);
    check("t5_clr_sticky", err_sticky, 0);

    // CEO divider
    step(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t6_wrap_start", wrap_cnt, 0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      ticks += int'(tick);
      if (i == 3) check("t6_tick_4th", tick, 1);
    end
    check("t6_ticks", ticks, 2);
    check("t6_wrap_end", wrap_cnt, 0);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t6_wrap3", wrap_cnt, 3);
    step(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_clr_tick", tick, 0);
    check("t6_clr_wrap", wrap_cnt, 0);

    // Asynchronous reset mid-run
    step(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_pre_rst_err", err_cnt, 1);
    #2 clr_n = 1'b0;
    #1;
    check("t6_rst_code_err", code_err, 0);
    check("t6_rst_err_cnt", err_cnt, 0);
    check("t6_rst_sticky", err_sticky, 0);
    check("t6_rst_wrap", wrap_cnt, 0);
    @(negedge clk);
    clr_n = 1'b1;
    step(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_first_seq", seq_err, 0);
    check("t6_first_phase", phase, 8'h10);
    check("t6_first_idx", idx, 4);

    // Randomized run of a mostly well-behaved counter
    rc = 0;
    for (int n = 0; n < 3000; n++) begin
      cev  = $urandom_range(0, 99) < 75;
      clrv = $urandom_range(0, 99) < 5;
      ecv  = $urandom_range(0, 99) < 4;
      qv   = ($urandom_range(0, 99) < 8) ? 4'($urandom) : codes[rc];
      ceov = ($urandom_range(0, 99) < 10) ? 1'($urandom) : (cev && qv == 4'hf);
      step(qv, cev, clrv, ceov, ecv);
      rc = clrv ? 0 : (cev ? (rc + 1) % 8 : rc);
      if ($urandom_range(0, 499) == 0) begin
        #1 clr_n = 1'b0;
        #1 clr_n = 1'b1;
        rc = 0;
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
